// File: rtl/ecc_156_selftest_ctrl_if.sv
// Bundle between the self-test controller and its environment: decoder mux,
// golden-pattern encoder hookup, run control and run status.
interface ecc_156_selftest_ctrl_if #(
  parameter int unsigned DATA_WIDTH   = 156,
  parameter int unsigned PARITY_WIDTH = 9,
  parameter int unsigned PERIOD_W     = 16
);
  logic                    test_en;
  logic [PERIOD_W-1:0]     test_period;
  logic                    test_start;
  logic                    func_vld;
  logic [DATA_WIDTH-1:0]   func_data;
  logic [PARITY_WIDTH-1:0] func_parity;
  logic [DATA_WIDTH-1:0]   enc_data;
  logic [PARITY_WIDTH-1:0] enc_parity;
  logic [DATA_WIDTH-1:0]   dec_data;
  logic [PARITY_WIDTH-1:0] dec_parity;
  logic                    dec_sel_test;
  logic [DATA_WIDTH-1:0]   dec_data_out;
  logic                    dec_sbit_err;
  logic                    dec_dbit_err;
  logic                    dec_ecc_fault;
  logic                    busy;
  logic                    done;
  logic                    fail;
  logic [2:0]              fail_code;
  logic [7:0]              run_cnt;

  modport slave (
    input  test_en, test_period, test_start, func_vld, func_data, func_parity,
           enc_parity, dec_data_out, dec_sbit_err, dec_dbit_err, dec_ecc_fault,
    output enc_data, dec_data, dec_parity, dec_sel_test,
           busy, done, fail, fail_code, run_cnt
  );

  modport master (
    output test_en, test_period, test_start, func_vld, func_data, func_parity,
           enc_parity, dec_data_out, dec_sbit_err, dec_dbit_err, dec_ecc_fault,
    input  enc_data, dec_data, dec_parity, dec_sel_test,
           busy, done, fail, fail_code, run_cnt
  );
endinterface

// File: rtl/ecc_156_selftest_ctrl.sv
// Online self-test scheduler for the shared SECDED decoder: steals idle decoder
// cycles to check a clean, a single-flip and a double-flip codeword per run.
module ecc_156_selftest_ctrl #(
  parameter int unsigned DATA_WIDTH   = 156,
  parameter int unsigned PARITY_WIDTH = 9,
  parameter int unsigned PERIOD_W     = 16
) (
  input logic                   clk,
  input logic                   rst,
  ecc_156_selftest_ctrl_if.slave bus
);

  localparam int unsigned K_W = $clog2(DATA_WIDTH);
  localparam int unsigned REP = (DATA_WIDTH + 15) / 16;
  localparam logic [K_W-1:0] K_LAST    = K_W'(DATA_WIDTH - 1);
  localparam logic [15:0]    LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_CLEAN, S_SBIT, S_DBIT, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic [2:0]            fail_code_q, fail_code_d;
  logic [7:0]            run_cnt_q, run_cnt_d;

  logic                    step_c;
  logic                    sel_test_c;
  logic [K_W-1:0]          k2_c;
  logic [DATA_WIDTH-1:0]   pattern_c;
  logic [DATA_WIDTH-1:0]   test_data_c;
  logic [PARITY_WIDTH-1:0] dec_parity_c;
  logic [PERIOD_W-1:0]     period_last_c;
  logic                    clean_ok_c, sbit_ok_c, dbit_ok_c;
  logic                    lfsr_fb_c;

  // Test vector generation and decoder input mux; functional reads always win.
  always_comb begin
    step_c        = (state_q == S_CLEAN) || (state_q == S_SBIT) || (state_q == S_DBIT);
    sel_test_c    = step_c & ~bus.func_vld;
    k2_c          = (k_q == K_LAST) ? '0 : k_q + K_W'(1);
    pattern_c     = DATA_WIDTH'({REP{lfsr_q}});
    test_data_c   = pattern_c;
    if (state_q == S_SBIT) begin
      test_data_c = pattern_c ^ (DATA_WIDTH'(1) << k_q);
    end else if (state_q == S_DBIT) begin
      test_data_c = pattern_c ^ (DATA_WIDTH'(1) << k_q) ^ (DATA_WIDTH'(1) << k2_c);
    end
    dec_parity_c  = sel_test_c ? bus.enc_parity : bus.func_parity;
    period_last_c = (bus.test_period == '0) ? '0 : bus.test_period - PERIOD_W'(1);
    lfsr_fb_c     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    clean_ok_c    = !bus.dec_sbit_err && !bus.dec_dbit_err && !bus.dec_ecc_fault &&
                    (bus.dec_data_out == pattern_c);
    sbit_ok_c     = bus.dec_sbit_err && !bus.dec_dbit_err && !bus.dec_ecc_fault &&
                    (bus.dec_data_out == pattern_c);
    dbit_ok_c     = bus.dec_dbit_err && !bus.dec_ecc_fault;
  end

  assign bus.enc_data     = pattern_c;
  assign bus.dec_sel_test = sel_test_c;
  assign bus.dec_data     = sel_test_c ? test_data_c : bus.func_data;
  assign bus.dec_parity   = dec_parity_c;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.fail         = fail_q;
  assign bus.fail_code    = fail_code_q;
  assign bus.run_cnt      = run_cnt_q;

  // Next-state and status update; a step only checks and advances on a free decoder cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    lfsr_d      = lfsr_q;
    fail_d      = fail_q;
    fail_code_d = fail_code_q;
    run_cnt_d   = run_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.test_start) begin
          state_d     = S_CLEAN;
          cnt_d       = '0;
          fail_code_d = '0;
        end else if (bus.test_en) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (bus.test_start || (bus.test_en && cnt_q == period_last_c)) begin
          state_d     = S_CLEAN;
          cnt_d       = '0;
          fail_code_d = '0;
        end else if (!bus.test_en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      S_CLEAN: begin
        if (!bus.func_vld) begin
          state_d = S_SBIT;
          if (!clean_ok_c) begin
            fail_code_d[2] = 1'b1;
            fail_d         = 1'b1;
          end
        end
      end
      S_SBIT: begin
        if (!bus.func_vld) begin
          state_d = S_DBIT;
          if (!sbit_ok_c) begin
            fail_code_d[1] = 1'b1;
            fail_d         = 1'b1;
          end
        end
      end
      S_DBIT: begin
        if (!bus.func_vld) begin
          state_d   = S_DONE;
          run_cnt_d = run_cnt_q + 8'd1;
          if (!dbit_ok_c) begin
            fail_code_d[0] = 1'b1;
            fail_d         = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = bus.test_en ? S_WAIT : S_IDLE;
        k_d     = k2_c;
        lfsr_d  = {lfsr_fb_c, lfsr_q[15:1]};
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CLEAN) || (state_d == S_SBIT) ||
             (state_d == S_DBIT)  || (state_d == S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      lfsr_q      <= LFSR_SEED;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_code_q <= '0;
      run_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      lfsr_q      <= lfsr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_code_q <= fail_code_d;
      run_cnt_q   <= run_cnt_d;
    end
  end

endmodule
